// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction fetch, data-memory handshake and datapath strobes of multicycle_control
interface multicycle_control_if #(
   parameter int OPCODE_W = 8,
   parameter int ALUOP_W = 8,
   parameter int CNT_W = 16
);
   logic instr_valid, mem_ready, err_clr;
   logic [OPCODE_W-1:0] opcode;
   logic fetch_req, regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite;
   logic [ALUOP_W-1:0] aluOp;
   logic illegal, mem_err;
   logic [CNT_W-1:0] retired;
   modport master (
      output instr_valid, opcode, mem_ready, err_clr,
      input fetch_req, regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite, aluOp, illegal, mem_err, retired
   );
   modport slave (
      input instr_valid, opcode, mem_ready, err_clr,
      output fetch_req, regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite, aluOp, illegal, mem_err, retired
   );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB control sequencer with registered strobes, error flags and retire counter
module multicycle_control #(
   parameter int OPCODE_W = 8,
   parameter int ALUOP_W = 8,
   parameter int CNT_W = 16,
   parameter int MEM_TIMEOUT = 16
) (
   input logic clk,
   input logic rst_n,
   multicycle_control_if.slave bus
);
   localparam int TW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [OPCODE_W-1:0] OP_NOP = '0;
   localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(8'h01);
   localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(8'h02);
   localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(8'h03);
   localparam logic [OPCODE_W-1:0] OP_OR = OPCODE_W'(8'h04);
   localparam logic [OPCODE_W-1:0] OP_LD = OPCODE_W'(8'h10);
   localparam logic [OPCODE_W-1:0] OP_ST = OPCODE_W'(8'h11);
   localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(8'h20);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(8'h30);
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
   typedef struct packed {
      logic fetch_req, reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
      logic [ALUOP_W-1:0] alu_op;
   } strb_t;
   state_t state_q, state_d;
   logic [OPCODE_W-1:0] op_q, op_d;
   logic [TW-1:0] mcnt_q, mcnt_d;
   logic [CNT_W-1:0] ret_q;
   logic ill_q, merr_q, ill_set, merr_set, retire;
   logic r, ld, st, ai, bq, nop;
   strb_t strb_q;
   function automatic logic [5:0] cls(input logic [OPCODE_W-1:0] o);
      return {o inside {OP_ADD, OP_SUB, OP_AND, OP_OR}, o == OP_LD, o == OP_ST, o == OP_ADDI, o == OP_BEQ, o == OP_NOP};
   endfunction
   function automatic strb_t decode(input state_t s, input logic [OPCODE_W-1:0] o);
      logic dr, dl, ds, da, db, dn, act;
      strb_t t;
      {dr, dl, ds, da, db, dn} = cls(o);
      act = s == EXEC || s == MEM || s == WB;
      t.fetch_req = s == FETCH;
      t.reg_dst = dr && (s == EXEC || s == WB);
      t.branch = db && s == EXEC;
      t.mem_read = dl && s == MEM;
      t.mem_to_reg = dl && (s == MEM || s == WB);
      t.mem_write = ds && s == MEM;
      t.alu_src = (dl || ds || da) && act;
      t.reg_write = s == WB;
      t.alu_op = !act ? '0 : dr ? ALUOP_W'(o[2:0]) : db ? ALUOP_W'(2) : (dl || ds || da) ? ALUOP_W'(1) : '0;
      return t;
   endfunction
   always_comb begin
      {r, ld, st, ai, bq, nop} = cls(op_q);
      state_d = state_q;
      op_d = op_q;
      mcnt_d = mcnt_q;
      ill_set = 1'b0;
      merr_set = 1'b0;
      retire = 1'b0;
      unique case (state_q)
         FETCH: begin
            // an instruction is only accepted once fetch_req is visible, i.e. not on the first edge after reset
            op_d = bus.instr_valid && strb_q.fetch_req ? bus.opcode : op_q;
            state_d = bus.instr_valid && strb_q.fetch_req ? DECODE : FETCH;
         end
         DECODE: begin
            ill_set = !(r || ld || st || ai || bq || nop);
            state_d = ill_set ? FETCH : EXEC;
         end
         EXEC: begin
            retire = nop || bq;
            mcnt_d = '0;
            state_d = retire ? FETCH : (ld || st) ? MEM : WB;
         end
         MEM: begin
            merr_set = !bus.mem_ready && MEM_TIMEOUT != 0 && mcnt_q == TW'(MEM_TIMEOUT - 1);
            retire = bus.mem_ready && st;
            mcnt_d = mcnt_q + 1'b1;
            state_d = bus.mem_ready ? (ld ? WB : FETCH) : merr_set ? FETCH : MEM;
         end
         WB: begin
            retire = 1'b1;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         op_q <= '0;
         mcnt_q <= '0;
         ret_q <= '0;
         ill_q <= 1'b0;
         merr_q <= 1'b0;
         strb_q <= '0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         mcnt_q <= mcnt_d;
         ret_q <= ret_q + CNT_W'(retire);
         ill_q <= ill_set || (ill_q && !bus.err_clr);
         merr_q <= merr_set || (merr_q && !bus.err_clr);
         strb_q <= decode(state_d, op_d);
      end
   end
   assign bus.fetch_req = strb_q.fetch_req;
   assign bus.regDst = strb_q.reg_dst;
   assign bus.branch = strb_q.branch;
   assign bus.memRead = strb_q.mem_read;
   assign bus.memToReg = strb_q.mem_to_reg;
   assign bus.memWrite = strb_q.mem_write;
   assign bus.aluSrc = strb_q.alu_src;
   assign bus.regWrite = strb_q.reg_write;
   assign bus.aluOp = strb_q.alu_op;
   assign bus.illegal = ill_q;
   assign bus.mem_err = merr_q;
   assign bus.retired = ret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and random instructions checked cycle by cycle against a stage-trace model
module tb_multicycle_control;
   localparam int TMO = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0, n_fail = 0;
   int ret = 0;
   bit ill = 0, merr = 0;
   multicycle_control_if #(.OPCODE_W(8), .ALUOP_W(8), .CNT_W(4)) bus ();
   multicycle_control #(.OPCODE_W(8), .ALUOP_W(8), .CNT_W(4), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );
   always #5 clk = ~clk;
   function automatic logic [21:0] vec();
      return {bus.fetch_req, bus.regDst, bus.branch, bus.memRead, bus.memToReg, bus.memWrite, bus.aluSrc,
              bus.regWrite, bus.aluOp, bus.illegal, bus.mem_err, bus.retired};
   endfunction
   // expected outputs while an instruction with opcode op sits in stage s (F/D/E/M/W)
   function automatic logic [21:0] expv(input logic [7:0] op, input byte s);
      bit r = op inside {8'h01, 8'h02, 8'h03, 8'h04};
      bit ld = op == 8'h10, st = op == 8'h11, ai = op == 8'h30, bq = op == 8'h20;
      bit act = s inside {"E", "M", "W"};
      logic [7:0] alu = r ? op : (ld || st || ai) ? 8'd1 : bq ? 8'd2 : 8'd0;
      logic [3:0] rv = 4'(ret);
      return {s == "F", r && (s == "E" || s == "W"), bq && s == "E", ld && s == "M", ld && (s == "M" || s == "W"),
              st && s == "M", (ld || st || ai) && act, s == "W", act ? alu : 8'd0, ill, merr, rv};
   endfunction
   task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // rdy_at: MEM cycle (1-based) that sees mem_ready; outside 1..TMO means never
   task automatic run(input logic [7:0] op, input int rdy_at, input int clr_pct, input bit clr_d);
      byte stg[$];
      bit ld = op == 8'h10, st = op == 8'h11;
      bit legal = op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h20, 8'h30};
      bit ok = rdy_at >= 1 && rdy_at <= TMO;
      bit wb = op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h30} || (ld && ok);
      int n = ok ? rdy_at : TMO;
      int m = 0;
      stg.push_back("D");
      if (legal) begin
         stg.push_back("E");
         if (ld || st) repeat (n) stg.push_back("M");
         if (wb) stg.push_back("W");
      end
      chk($sformatf("op%02h_F", op), vec(), expv(op, "F"));
      bus.instr_valid = 1'b1;
      bus.opcode = op;
      bus.mem_ready = 1'($urandom);
      bus.err_clr = !clr_d && $urandom_range(99) < clr_pct;
      @(posedge clk); #1;
      ill = ill && !bus.err_clr;
      merr = merr && !bus.err_clr;
      foreach (stg[i]) begin
         chk($sformatf("op%02h_%c%0d", op, stg[i], i), vec(), expv(op, stg[i]));
         bus.instr_valid = 1'($urandom);
         bus.opcode = 8'($urandom);
         bus.err_clr = clr_d ? stg[i] == "D" : $urandom_range(99) < clr_pct;
         if (stg[i] == "M") begin
            m++;
            bus.mem_ready = m == rdy_at;
         end else bus.mem_ready = 1'($urandom);
         @(posedge clk); #1;
         ill = (stg[i] == "D" && !legal) || (ill && !bus.err_clr);
         merr = (i == stg.size() - 1 && (ld || st) && !ok) || (merr && !bus.err_clr);
      end
      if (legal && !((ld || st) && !ok)) ret = (ret + 1) % 16;
      bus.instr_valid = 1'b0;
      bus.err_clr = 1'b0;
      bus.mem_ready = 1'b0;
      chk($sformatf("op%02h_done", op), vec(), expv(8'h00, "F"));
   endtask
   task automatic reset_release();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_release", vec(), expv(8'h00, "F"));
   endtask
   initial begin
      logic [7:0] ops [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h20, 8'h30, 8'hFF};
      bus.instr_valid = 1'b0;
      bus.opcode = '0;
      bus.mem_ready = 1'b0;
      bus.err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("in_reset", vec(), 22'h0);
      reset_release();
      run(8'h01, 0, 0, 0);
      run(8'h10, 3, 0, 0);
      run(8'h11, 99, 0, 0);
      bus.err_clr = 1'b1;
      @(posedge clk); #1;
      bus.err_clr = 1'b0;
      ill = 0;
      merr = 0;
      chk("err_clr", vec(), expv(8'h00, "F"));
      run(8'hFF, 0, 0, 0);
      run(8'hFF, 0, 0, 1);
      run(8'h10, 0, 0, 0);
      run(8'h10, 1, 0, 0);
      run(8'h11, TMO, 0, 0);
      bus.instr_valid = 1'b1;
      bus.opcode = 8'h10;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      bus.mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_abort_M", vec(), expv(8'h10, "M"));
      rst_n = 1'b0;
      #1;
      ret = 0;
      ill = 0;
      merr = 0;
      chk("abort", vec(), 22'h0);
      reset_release();
      repeat (16) run(8'h00, 0, 0, 0);
      chk("wrap16", 22'(bus.retired), 22'h0);
      run(8'h00, 0, 0, 0);
      chk("wrap17", 22'(bus.retired), 22'h1);
      for (int k = 0; k < 40; k++) begin
         int sel = $urandom_range(9);
         logic [7:0] op = sel == 9 ? 8'($urandom) : ops[sel];
         run(op, $urandom_range(TMO + 2), 10, 0);
         repeat ($urandom_range(2)) begin
            @(posedge clk); #1;
            chk("idle", vec(), expv(8'h00, "F"));
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
